// File: rtl/sdrc_app_front_pkg.sv
// Shared types and widths for the SDRAM application front end.
package sdrc_app_front_pkg;

    localparam int unsigned ADDR_W = 26;
    localparam int unsigned LEN_W  = 9;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned STAT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WDATA = 2'd2
    } fe_state_e;

    // Queued host command, field order matches the app_req_* outputs.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic              wr_n;
        logic              wrap;
    } cmd_t;

    // One buffered write beat.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be_n;
    } wbeat_t;

    // A command is unusable when it has no beats, or is a write longer than the data buffer.
    function automatic logic len_bad(input cmd_t c, input int unsigned max_len);
        return (c.len == '0) || (!c.wr_n && (c.len > LEN_W'(max_len)));
    endfunction

endpackage

// File: rtl/sdrc_sync_fifo.sv
// Single-clock FIFO with registered storage and a combinational head view.
// A push while full is dropped even if a pop happens in the same cycle.
module sdrc_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = cnt_q;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage; contents are don't-care while the FIFO is empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/sdrc_app_front.sv
// Application front end for the SDRAM core: buffers host commands and write
// data, and issues a write only once its whole burst is buffered.
// Optional request statistics: define SDRC_APP_FRONT_STATS_EN.
module sdrc_app_front
    import sdrc_app_front_pkg::*;
#(
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned WD_DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_wr_n,
    input  logic              cmd_wrap,
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DATA_W-1:0] wd_data,
    input  logic [BE_W-1:0]   wd_be_n,
    output logic              app_req,
    output logic [ADDR_W-1:0] app_req_addr,
    output logic [LEN_W-1:0]  app_req_len,
    output logic              app_req_wr_n,
    output logic              app_req_wrap,
    input  logic              app_req_ack,
    input  logic              app_wr_next_req,
    output logic [DATA_W-1:0] app_wr_data,
    output logic [BE_W-1:0]   app_wr_en_n,
    input  logic              app_last_wr,
    input  logic              sdr_init_done,
    output logic              fe_idle,
    output logic              err_len,
    output logic              err_unf
`ifdef SDRC_APP_FRONT_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_wr_req,
    output logic [STAT_W-1:0] stat_rd_req
`endif
);

    localparam int unsigned CMD_CNT_W = $clog2(CMD_DEPTH) + 1;
    localparam int unsigned WD_CNT_W  = $clog2(WD_DEPTH) + 1;

    fe_state_e            state_q, state_d;
    cmd_t                 cmd_in, cmd_head;
    cmd_t                 req_q, req_d;
    wbeat_t               wd_in, wd_head;
    logic                 alive_q, alive_d;
    logic                 app_req_q, app_req_d;
    logic                 err_len_q, err_len_d;
    logic                 err_unf_q, err_unf_d;
    logic                 cmd_full, cmd_empty, wd_full, wd_empty;
    logic [CMD_CNT_W-1:0] cmd_count;
    logic [WD_CNT_W-1:0]  wd_count;
    logic                 cmd_fire, cmd_bad, cmd_push, cmd_pop;
    logic                 wd_push, wd_pop, ack_fire;

    assign cmd_in = '{addr: cmd_addr, len: cmd_len, wr_n: cmd_wr_n, wrap: cmd_wrap};
    assign wd_in  = '{data: wd_data, be_n: wd_be_n};

    // alive_q holds the ready outputs low while reset is asserted.
    assign cmd_ready = alive_q && !cmd_full;
    assign wd_ready  = alive_q && !wd_full;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign cmd_bad   = len_bad(cmd_in, WD_DEPTH);
    assign cmd_push  = cmd_fire && !cmd_bad;
    assign wd_push   = wd_valid && wd_ready;

    assign app_req      = app_req_q;
    assign app_req_addr = req_q.addr;
    assign app_req_len  = req_q.len;
    assign app_req_wr_n = req_q.wr_n;
    assign app_req_wrap = req_q.wrap;
    assign app_wr_data  = wd_head.data;
    assign app_wr_en_n  = wd_head.be_n;
    assign err_len      = err_len_q;
    assign err_unf      = err_unf_q;
    assign fe_idle      = (state_q == IDLE) && (cmd_count == '0) && (wd_count == '0);

    sdrc_sync_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (cmd_push),
        .din   (cmd_in),
        .pop   (cmd_pop),
        .dout  (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty),
        .count (cmd_count)
    );

    sdrc_sync_fifo #(
        .WIDTH ($bits(wbeat_t)),
        .DEPTH (WD_DEPTH)
    ) u_wd_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (wd_push),
        .din   (wd_in),
        .pop   (wd_pop),
        .dout  (wd_head),
        .full  (wd_full),
        .empty (wd_empty),
        .count (wd_count)
    );

    // Next state, FIFO pops and registered-output next values.
    always_comb begin
        state_d   = state_q;
        cmd_pop   = 1'b0;
        wd_pop    = 1'b0;
        ack_fire  = 1'b0;
        alive_d   = 1'b1;
        req_d     = req_q;
        err_len_d = cmd_fire && cmd_bad;
        err_unf_d = err_unf_q || (app_wr_next_req && wd_empty);

        unique case (state_q)
            IDLE: begin
                if (!cmd_empty && sdr_init_done &&
                    (cmd_head.wr_n || (LEN_W'(wd_count) >= cmd_head.len))) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                req_d = cmd_head;
                // Only an ack against a visible request counts.
                if (app_req_q && app_req_ack) begin
                    ack_fire = 1'b1;
                    cmd_pop  = 1'b1;
                    state_d  = cmd_head.wr_n ? IDLE : WDATA;
                end
            end
            WDATA: begin
                wd_pop = app_wr_next_req;
                if (app_last_wr) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        app_req_d = (state_q == REQ) && !ack_fire;
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            alive_q   <= 1'b0;
            app_req_q <= 1'b0;
            req_q     <= '0;
            err_len_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            alive_q   <= alive_d;
            app_req_q <= app_req_d;
            req_q     <= req_d;
            err_len_q <= err_len_d;
            err_unf_q <= err_unf_d;
        end
    end

`ifdef SDRC_APP_FRONT_STATS_EN
    logic [STAT_W-1:0] stat_wr_q, stat_wr_d;
    logic [STAT_W-1:0] stat_rd_q, stat_rd_d;

    assign stat_wr_req = stat_wr_q;
    assign stat_rd_req = stat_rd_q;

    // Saturating counts of acknowledged requests by type.
    always_comb begin
        stat_wr_d = stat_wr_q;
        stat_rd_d = stat_rd_q;
        if (ack_fire && !cmd_head.wr_n && (stat_wr_q != '1)) begin
            stat_wr_d = stat_wr_q + STAT_W'(1);
        end
        if (ack_fire && cmd_head.wr_n && (stat_rd_q != '1)) begin
            stat_rd_d = stat_rd_q + STAT_W'(1);
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_wr_q <= '0;
            stat_rd_q <= '0;
        end else begin
            stat_wr_q <= stat_wr_d;
            stat_rd_q <= stat_rd_d;
        end
    end
`endif

endmodule

// File: tb/tb_sdrc_app_front.sv
// Directed bench for sdrc_app_front with request and write-data scoreboards.
module tb_sdrc_app_front;
    import sdrc_app_front_pkg::*;

    localparam int unsigned CMD_DEPTH = 4;
    localparam int unsigned WD_DEPTH  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic              cmd_wr_n = 1'b0;
    logic              cmd_wrap = 1'b0;
    logic              wd_valid = 1'b0;
    logic              wd_ready;
    logic [DATA_W-1:0] wd_data = '0;
    logic [BE_W-1:0]   wd_be_n = '0;
    logic              app_req;
    logic [ADDR_W-1:0] app_req_addr;
    logic [LEN_W-1:0]  app_req_len;
    logic              app_req_wr_n;
    logic              app_req_wrap;
    logic              app_req_ack = 1'b0;
    logic              app_wr_next_req = 1'b0;
    logic [DATA_W-1:0] app_wr_data;
    logic [BE_W-1:0]   app_wr_en_n;
    logic              app_last_wr = 1'b0;
    logic              sdr_init_done = 1'b1;
    logic              fe_idle;
    logic              err_len;
    logic              err_unf;
`ifdef SDRC_APP_FRONT_STATS_EN
    logic [STAT_W-1:0] stat_wr_req;
    logic [STAT_W-1:0] stat_rd_req;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    cmd_t   exp_req[$];
    wbeat_t exp_wd[$];

    always #5 clk = ~clk;

    sdrc_app_front #(
        .CMD_DEPTH (CMD_DEPTH),
        .WD_DEPTH  (WD_DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_addr        (cmd_addr),
        .cmd_len         (cmd_len),
        .cmd_wr_n        (cmd_wr_n),
        .cmd_wrap        (cmd_wrap),
        .wd_valid        (wd_valid),
        .wd_ready        (wd_ready),
        .wd_data         (wd_data),
        .wd_be_n         (wd_be_n),
        .app_req         (app_req),
        .app_req_addr    (app_req_addr),
        .app_req_len     (app_req_len),
        .app_req_wr_n    (app_req_wr_n),
        .app_req_wrap    (app_req_wrap),
        .app_req_ack     (app_req_ack),
        .app_wr_next_req (app_wr_next_req),
        .app_wr_data     (app_wr_data),
        .app_wr_en_n     (app_wr_en_n),
        .app_last_wr     (app_last_wr),
        .sdr_init_done   (sdr_init_done),
        .fe_idle         (fe_idle),
        .err_len         (err_len),
        .err_unf         (err_unf)
`ifdef SDRC_APP_FRONT_STATS_EN
        ,
        .stat_wr_req     (stat_wr_req),
        .stat_rd_req     (stat_rd_req)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] req_obs();
        cmd_t c;
        c = '{addr: app_req_addr, len: app_req_len, wr_n: app_req_wr_n, wrap: app_req_wrap};
        return 64'(c);
    endfunction

    // Offer one command and wait for the handshake; scoreboard it if it is legal.
    task automatic send_cmd(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l,
                            input logic wn, input logic wp);
        cmd_t c;
        c = '{addr: a, len: l, wr_n: wn, wrap: wp};
        cmd_addr  = a;
        cmd_len   = l;
        cmd_wr_n  = wn;
        cmd_wrap  = wp;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !cmd_ready; i++) step();
        check("cmd_accept", 64'(cmd_ready), 64'd1);
        step();
        cmd_valid = 1'b0;
        if (l != 0 && (wn || l <= LEN_W'(WD_DEPTH))) exp_req.push_back(c);
    endtask

    // Offer one write beat and wait for the handshake.
    task automatic send_wd(input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
        wbeat_t w;
        w = '{data: d, be_n: be};
        wd_data  = d;
        wd_be_n  = be;
        wd_valid = 1'b1;
        for (int i = 0; i < 50 && !wd_ready; i++) step();
        check("wd_accept", 64'(wd_ready), 64'd1);
        step();
        wd_valid = 1'b0;
        exp_wd.push_back(w);
    endtask

    // Act as the core: wait for a request, check it, ack it, then consume write
    // beats (all of them when beats < 0, else only that many, without last).
    task automatic serve_req(input int beats);
        cmd_t   e;
        wbeat_t w;
        int     n;
        for (int i = 0; i < 40 && !app_req; i++) step();
        check("req_seen", 64'(app_req), 64'd1);
        if (app_req !== 1'b1) return;
        check("req_sb_nonempty", 64'(exp_req.size() != 0), 64'd1);
        if (exp_req.size() == 0) return;
        e = exp_req.pop_front();
        check("req_fields", req_obs(), 64'(e));
        app_req_ack = 1'b1;
        step();
        app_req_ack = 1'b0;
        check("req_fall", 64'(app_req), 64'd0);
        if (e.wr_n) return;
        n = (beats < 0) ? int'(e.len) : beats;
        for (int i = 0; i < n; i++) begin
            if (exp_wd.size() == 0) begin
                check("wd_sb_nonempty", 64'd0, 64'd1);
                break;
            end
            w = exp_wd.pop_front();
            check("wr_data", 64'(app_wr_data), 64'(w.data));
            check("wr_en_n", 64'(app_wr_en_n), 64'(w.be_n));
            app_wr_next_req = 1'b1;
            app_last_wr     = (beats < 0) && (i == n - 1);
            step();
        end
        app_wr_next_req = 1'b0;
        app_last_wr     = 1'b0;
    endtask

    initial begin
        cmd_t e;
        bit   stable;
        bit   saw_req;

        // Values while reset is held.
        #2;
        check("rst_app_req", 64'(app_req), 64'd0);
        check("rst_req_fields", req_obs(), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_wd_ready", 64'(wd_ready), 64'd0);
        check("rst_fe_idle", 64'(fe_idle), 64'd1);
        check("rst_err_len", 64'(err_len), 64'd0);
        check("rst_err_unf", 64'(err_unf), 64'd0);
        step();
        step();
        reset = 1'b0;
        step();
        step();
        check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("post_rst_wd_ready", 64'(wd_ready), 64'd1);

        // Read request: exact rise latency, held fields, fall after ack.
        send_cmd(26'h0001234, 9'd8, 1'b1, 1'b0);
        check("t1_err_len", 64'(err_len), 64'd0);
        check("t1_req_c0", 64'(app_req), 64'd0);
        step();
        check("t1_req_c1", 64'(app_req), 64'd0);
        step();
        check("t1_req_rise", 64'(app_req), 64'd1);
        e = exp_req.pop_front();
        check("t1_fields", req_obs(), 64'(e));
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (app_req !== 1'b1 || req_obs() !== 64'(e)) stable = 1'b0;
        end
        check("t1_hold_stable", 64'(stable), 64'd1);
        app_req_ack = 1'b1;
        step();
        app_req_ack = 1'b0;
        check("t1_req_fall", 64'(app_req), 64'd0);
        check("t1_fe_idle", 64'(fe_idle), 64'd1);

        // Write len 4: no request until the 4th beat is buffered.
        send_cmd(26'h00ABCDE, 9'd4, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_wd(32'hA000_0000 + 32'(i), 4'(i));
        repeat (4) step();
        check("t2_no_req_partial", 64'(app_req), 64'd0);
        send_wd(32'hA000_0003, 4'h3);
        serve_req(-1);
        step();
        check("t2_fe_idle", 64'(fe_idle), 64'd1);
        check("t2_err_unf", 64'(err_unf), 64'd0);

        // Over-long write and zero-length read are dropped with an err_len pulse.
        send_cmd(26'h0000100, 9'd17, 1'b0, 1'b0);
        check("t3_err_len_pulse", 64'(err_len), 64'd1);
        step();
        check("t3_err_len_clear", 64'(err_len), 64'd0);
        check("t3_fe_idle", 64'(fe_idle), 64'd1);
        send_cmd(26'h0000200, 9'd0, 1'b1, 1'b0);
        check("t3_err_len_rd0", 64'(err_len), 64'd1);
        repeat (3) step();
        check("t3_no_req", 64'(app_req), 64'd0);

        // Write of exactly WD_DEPTH beats fills the data FIFO; wrap bit carried.
        send_cmd(26'h3FFFFF0, 9'd16, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) send_wd(32'h5A5A_0000 ^ (32'(i) << 4), 4'(15 - i));
        check("t3_wd_full", 64'(wd_ready), 64'd0);
        serve_req(-1);
        step();
        check("t3_wd_drained", 64'(fe_idle), 64'd1);

        // Command FIFO full: 5th held off until the first is acknowledged.
        for (int k = 0; k < 4; k++) send_cmd(26'h0000100 + 26'(k), 9'd1, 1'b1, 1'b0);
        check("t4_cmd_full", 64'(cmd_ready), 64'd0);
        cmd_addr  = 26'h0000104;
        cmd_len   = 9'd1;
        cmd_wr_n  = 1'b1;
        cmd_wrap  = 1'b0;
        cmd_valid = 1'b1;
        step();
        step();
        check("t4_still_full", 64'(cmd_ready), 64'd0);
        serve_req(-1);
        check("t4_ready_after_ack", 64'(cmd_ready), 64'd1);
        e = '{addr: 26'h0000104, len: 9'd1, wr_n: 1'b1, wrap: 1'b0};
        exp_req.push_back(e);
        step();
        cmd_valid = 1'b0;
        for (int k = 0; k < 4; k++) serve_req(-1);
        step();
        check("t4_fe_idle", 64'(fe_idle), 64'd1);

        // Reset in the middle of a write burst, with another command queued.
        send_cmd(26'h0002000, 9'd4, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) send_wd(32'hC0DE_0000 + 32'(i), 4'hF - 4'(i));
        send_cmd(26'h0003000, 9'd2, 1'b1, 1'b0);
        serve_req(2);
        check("t5_busy", 64'(fe_idle), 64'd0);
        reset = 1'b1;
        #1;
        check("t5_rst_app_req", 64'(app_req), 64'd0);
        check("t5_rst_fe_idle", 64'(fe_idle), 64'd1);
        check("t5_rst_cmd_ready", 64'(cmd_ready), 64'd0);
        exp_req.delete();
        exp_wd.delete();
        step();
        reset = 1'b0;
        step();
        check("t5_fe_idle_after", 64'(fe_idle), 64'd1);
        saw_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (app_req === 1'b1) saw_req = 1'b1;
        end
        check("t5_no_stale_req", 64'(saw_req), 64'd0);

        // Three writes and two reads after that reset.
        for (int i = 0; i < 3; i++) begin
            send_cmd(26'h0010000 + 26'(i * 16), 9'd1, 1'b0, 1'b0);
            send_wd(32'h1234_5670 + 32'(i), 4'h0);
            serve_req(-1);
        end
        for (int i = 0; i < 2; i++) begin
            send_cmd(26'h0020000 + 26'(i * 16), 9'd2, 1'b1, 1'b0);
            serve_req(-1);
        end
        step();
`ifdef SDRC_APP_FRONT_STATS_EN
        check("stat_wr_req", 64'(stat_wr_req), 64'd3);
        check("stat_rd_req", 64'(stat_rd_req), 64'd2);
`endif
        check("t6_err_unf_clear", 64'(err_unf), 64'd0);

        // Beat request with no buffered data sets the sticky underflow flag.
        app_wr_next_req = 1'b1;
        step();
        app_wr_next_req = 1'b0;
        check("t7_err_unf_set", 64'(err_unf), 64'd1);
        step();
        step();
        check("t7_err_unf_sticky", 64'(err_unf), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sdrc_app_front.md
# sdrc_app_front

Single-clock application front end that queues host memory commands and write data, then drives the SDRAM core's application request port. It sits directly upstream of the SDRAM controller core. It holds each request on `app_req` until the core acknowledges it. For writes, it supplies write data beat by beat on `app_wr_next_req` and never underruns, because a write is issued only once its full burst is buffered.

## Interface
- `CMD_DEPTH`, 4: command FIFO entries (power of 2)
- `WD_DEPTH`, 16: write-data FIFO entries (power of 2); maximum write burst length
- `clk` in 1: single clock for the whole block, the same clock as the core
- `reset` in 1: asynchronous, active-high; clears all state
- `cmd_valid` in 1: host command offered
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`
- `cmd_addr` in 26: word address
- `cmd_len` in 9: burst length in 32-bit beats, 1..256
- `cmd_wr_n` in 1: 0 = write, 1 = read
- `cmd_wrap` in 1: wrap burst
- `wd_valid`, `wd_ready` in/out 1: write-data handshake
- `wd_data` in 32: write word
- `wd_be_n` in 4: byte enables, active low
- `app_req` out 1: request to core
- `app_req_addr` out 26
- `app_req_len` out 9
- `app_req_wr_n` out 1
- `app_req_wrap` out 1
- `app_req_ack` in 1: request acknowledge from core
- `app_wr_next_req` in 1: core consumes one write beat this cycle
- `app_wr_data` out 32
- `app_wr_en_n` out 4
- `app_last_wr` in 1: last write beat consumed
- `sdr_init_done` in 1: the block issues nothing until this is high
- `fe_idle` out 1: both FIFOs empty and FSM in IDLE
- `err_len` out 1: one-cycle pulse when a write command is dropped for `cmd_len > WD_DEPTH`
- `err_unf` out 1: sticky flag, set if `app_wr_next_req` arrives while the write-data FIFO is empty

## Operation
- **Command FIFO.** Accepts when not full (`cmd_ready = !full`). A push is rejected when full, even if a pop occurs in the same cycle.
- **Length check.** A write command with `cmd_len > WD_DEPTH` or `cmd_len == 0` is consumed, dropped, and pulses `err_len`. A read with `cmd_len == 0` is also dropped and pulses `err_len`.
- **Write-data FIFO.** Same full and rejection rule as the command FIFO. `app_wr_data` and `app_wr_en_n` show the FIFO head combinationally from registered storage and pointers. The head is popped on each `app_wr_next_req` in state WDATA.
- **FSM states:** IDLE, REQ, WDATA.
  - IDLE → REQ when the command FIFO is non-empty, `sdr_init_done = 1`, and either the head is a read or the write-data count is ≥ head length.
  - REQ: `app_req` and the request fields are held stable. On `app_req_ack`, pop the command. A read goes to IDLE; a write goes to WDATA.
  - WDATA: pop one beat per `app_wr_next_req`. Go to IDLE on the cycle `app_last_wr` is high.
- **Read data** does not pass through this block.
- **Reset values:** `app_req` = 0, all `app_req_*` fields = 0, `cmd_ready` = 0 during reset and 1 afterwards, `wd_ready` = 0 during reset and 1 afterwards, `fe_idle` = 1, `err_len` = 0, `err_unf` = 0. The state is IDLE and the FIFOs are empty.
- **Reset mid-burst** discards all queued commands and data; no handshake completion is attempted.

## Timing
- `app_req` is registered. It rises on the cycle after the FSM enters REQ, which is 2 cycles after the qualifying condition.
- `app_req` falls on the cycle after `app_req_ack` is sampled high.
- Back-to-back requests have at least one idle cycle between `app_req` pulses.
- The write-data pop takes effect at the clock edge; the next head is visible on the following cycle.
- FIFO occupancy counts are `$clog2(DEPTH)+1` bits wide. Pointers wrap modulo DEPTH.

## Configuration
- `SDRC_APP_FRONT_STATS_EN`
  - **Defined:** adds output ports `stat_wr_req` and `stat_rd_req`, each 16 bits. Each counts acknowledged requests of its type, saturates at 0xFFFF, and is cleared by `reset`.
  - **Undefined:** the ports and counters are absent.

## Structure
- Package `sdrc_app_front_pkg`:
  - FSM state enum `{IDLE, REQ, WDATA}`
  - `ADDR_W = 26`, `LEN_W = 9`, `DATA_W = 32`
  - command struct: addr, len, wr_n, wrap
- Sub-module `sdrc_sync_fifo` (parameterized width and depth; push/pop, full, empty, count) is instantiated twice: once for commands, once for write data.

## Test plan
- After reset, `sdr_init_done = 1`, push a read with addr 0x0001234, len 8 → `app_req` rises 2 cycles later with addr 0x0001234, len 8, `wr_n = 1`. Hold `app_req_ack` off for 5 cycles → the fields stay stable. Ack → `app_req` falls the next cycle and `fe_idle = 1`.
- Push a write with len 4, then 3 data words → no `app_req`. Push the 4th word → `app_req` rises. Ack, then pulse `app_wr_next_req` 4 times with `app_last_wr` on the 4th → `app_wr_data` presents words 0–3 in order. FSM returns to IDLE and `err_unf = 0`.
- Push a write with len 17 (`WD_DEPTH = 16`) → `err_len` pulses for 1 cycle, no `app_req`, command FIFO empty.
- Push 5 commands with no ack → `cmd_ready = 0` after the 4th. The 5th is accepted only once the first is acknowledged.
- Assert `reset` while in WDATA after 2 of 4 beats → `app_req = 0`, `fe_idle = 1`, and both FIFOs are empty from the next edge.
- With `SDRC_APP_FRONT_STATS_EN` defined, issue 3 writes and 2 reads → `stat_wr_req = 3`, `stat_rd_req = 2`.
